// File: rtl/ex_mul_seq.sv
// ex_mul_seq: iterative shift-and-add multiplier for the EX stage.
// Retires BITS_PER_CYCLE multiplier bits per BUSY cycle and returns the low
// DATA_W bits of the product. While the multiply runs it holds the upstream
// pipeline registers and the PC.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        MUL instruction valid in EX
//   flush        kill the instruction in EX
//   op_a, op_b   multiplicand / multiplier (sampled on IDLE->BUSY only)
//   rd_in        destination register
//   stall        hold request for IF/ID, ID/EX and the PC
//   busy         state is BUSY
//   result_valid product valid this cycle (DONE, not flushed)
//   result       product, low DATA_W bits (held outside DONE)
//   rd_out       destination register tagged to result
module ex_mul_seq #(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [4:0]        rd_in,
  output logic              stall,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  output logic [4:0]        rd_out
);

  localparam int unsigned N    = DATA_W / BITS_PER_CYCLE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [4:0]          rd_tag_q, rd_tag_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [4:0]          rd_out_q, rd_out_d;
  logic [DATA_W-1:0]   acc_sum;

  // Partial products of the low BITS_PER_CYCLE multiplier bits; carries past
  // DATA_W-1 fall off, which yields the low half of the product.
  always_comb begin
    acc_sum = acc_q;
    for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mplier_q[k]) begin
        acc_sum = acc_sum + (mcand_q << k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rd_tag_d = rd_tag_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          rd_tag_d = rd_in;
          acc_d    = '0;
          cnt_d    = CntW'(N - 1);
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (flush) begin
          // Abandon the operation; result/rd_out keep their previous values.
          state_d = StIdle;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          if (cnt_q == '0) begin
            result_d = acc_sum;
            rd_out_d = rd_tag_q;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StDone: begin
        // start is ignored here: ID/EX still holds the same MUL.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rd_tag_q <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rd_tag_q <= rd_tag_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy         = (state_q == StBusy);
  assign stall        = (((state_q == StIdle) && start) || (state_q == StBusy)) && !flush;
  assign result_valid = (state_q == StDone) && !flush;
  assign result       = result_q;
  assign rd_out       = rd_out_q;

endmodule

// File: tb/tb_ex_mul_seq.sv
// Bench for ex_mul_seq: three instances (BITS_PER_CYCLE = 2, 1, 4) exercised
// one at a time against a reference product a*b mod 2^64 and the cycle timing
// IDLE(0) / BUSY(1..N) / DONE(N+1).
module tb_ex_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        start_v [3];
  logic        flush_v [3];
  logic        stall_w [3];
  logic        busy_w  [3];
  logic        valid_w [3];
  logic [63:0] res_w   [3];
  logic [4:0]  rdo_w   [3];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] last_res [3];
  logic [4:0]  last_rd  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Bpc = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    ex_mul_seq #(
      .DATA_W        (64),
      .BITS_PER_CYCLE(Bpc)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start_v[g]),
      .flush       (flush_v[g]),
      .op_a        (op_a),
      .op_b        (op_b),
      .rd_in       (rd_in),
      .stall       (stall_w[g]),
      .busy        (busy_w[g]),
      .result_valid(valid_w[g]),
      .result      (res_w[g]),
      .rd_out      (rdo_w[g])
    );
  end

  function automatic int bpc_of(input int s);
    return (s == 0) ? 2 : ((s == 1) ? 1 : 4);
  endfunction

  task automatic check(input string tag, input int s, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[bpc=%0d]: observed %h expected %h", tag, bpc_of(s), obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Called in an IDLE cycle (1 ns after the edge). Returns in the IDLE cycle
  // after DONE, with start left at 'hold'.
  task automatic run_mul(input int s, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] r, input bit hold, input bit flush_done);
    logic [63:0] exp;
    int          n;
    int          stall_cnt;
    exp       = a * b;
    n         = 64 / bpc_of(s);
    stall_cnt = 0;
    op_a = a; op_b = b; rd_in = r; start_v[s] = 1'b1;
    #1;
    check("c0_busy", s, busy_w[s], 0);
    stall_cnt += int'(stall_w[s]);
    for (int c = 1; c <= n; c++) begin
      tick();
      if (!hold) start_v[s] = 1'b0;
      op_a = rnd64(); op_b = rnd64(); rd_in = 5'($urandom());
      #1;
      stall_cnt += int'(stall_w[s]);
      if (c == 1 || c == n) check("busy_run", s, busy_w[s], 1);
      if (c == n) check("valid_early", s, valid_w[s], 0);
    end
    tick();
    if (flush_done) flush_v[s] = 1'b1;
    #1;
    check("stall_len", s, 64'(stall_cnt), 64'(n + 1));
    check("done_valid", s, valid_w[s], flush_done ? 0 : 1);
    check("done_result", s, res_w[s], exp);
    check("done_rd", s, rdo_w[s], r);
    check("done_stall", s, stall_w[s], 0);
    last_res[s] = exp;
    last_rd[s]  = r;
    tick();
    flush_v[s] = 1'b0;
    start_v[s] = hold;
    #1;
    check("idle_valid", s, valid_w[s], 0);
    check("idle_busy", s, busy_w[s], 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    op_a = '0; op_b = '0; rd_in = '0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; flush_v[i] = 1'b0; last_res[i] = '0; last_rd[i] = '0;
    end
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_result", i, res_w[i], 0);
      check("rst_rd", i, rdo_w[i], 0);
      check("rst_valid", i, valid_w[i], 0);
      check("rst_busy", i, busy_w[i], 0);
    end
    rst = 1'b0;
    tick();

    for (int s = 0; s < 3; s++) begin
      run_mul(s, 64'd3, 64'd5, 5'd7, 1'b0, 1'b0);
      run_mul(s, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 5'd1, 1'b0, 1'b0);
      run_mul(s, 64'h8000_0000_0000_0000, 64'd2, 5'd2, 1'b0, 1'b0);
      run_mul(s, 64'h1234, 64'h10, 5'd4, 1'b0, 1'b0);

      // Flush at BUSY cycle 10.
      op_a = rnd64(); op_b = rnd64(); rd_in = 5'd30; start_v[s] = 1'b1;
      tick();
      start_v[s] = 1'b0;
      for (int c = 2; c <= 10; c++) tick();
      flush_v[s] = 1'b1;
      #1;
      check("flush_stall", s, stall_w[s], 0);
      check("flush_valid", s, valid_w[s], 0);
      tick();
      flush_v[s] = 1'b0;
      #1;
      check("postflush_busy", s, busy_w[s], 0);
      check("postflush_valid", s, valid_w[s], 0);
      check("postflush_result", s, res_w[s], last_res[s]);
      check("postflush_rd", s, rdo_w[s], last_rd[s]);
      run_mul(s, 64'd6, 64'd7, 5'd5, 1'b0, 1'b0);

      // Reset at BUSY cycle 5.
      op_a = rnd64(); op_b = rnd64(); rd_in = 5'd9; start_v[s] = 1'b1;
      tick();
      start_v[s] = 1'b0;
      for (int c = 2; c <= 5; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("midrst_result", s, res_w[s], 0);
      check("midrst_rd", s, rdo_w[s], 0);
      check("midrst_stall", s, stall_w[s], 0);
      check("midrst_busy", s, busy_w[s], 0);
      check("midrst_valid", s, valid_w[s], 0);
      for (int i = 0; i < 3; i++) begin
        last_res[i] = '0; last_rd[i] = '0;
      end
      tick();

      // start held through DONE, then back-to-back 9x9.
      run_mul(s, rnd64(), rnd64(), 5'd10, 1'b1, 1'b0);
      check("hold_idle_stall", s, stall_w[s], 1);
      run_mul(s, 64'd9, 64'd9, 5'd3, 1'b0, 1'b0);

      // Flush in DONE suppresses result_valid.
      run_mul(s, rnd64(), rnd64(), 5'd12, 1'b0, 1'b1);

      for (int k = 0; k < 3; k++) begin
        run_mul(s, rnd64(), rnd64(), 5'($urandom()), 1'b0, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
